// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit -- single-outstanding instruction fetch with redirect and fault
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
  input  logic        DecodeReady,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        Fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    WAIT  = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic        load_instr;
  logic        clear_valid;
  logic        set_fault;
  logic        redirect;
  logic        misaligned;

  assign redirect   = PCSrc && (state != HALT);
  assign misaligned = |PCTarget[1:0];

  // Reset gating keeps the request low while reset is held, even though state is FETCH.
  assign imem_req  = (state == FETCH) && !PCSrc && !reset;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    load_instr    = 1'b0;
    clear_valid   = 1'b0;
    set_fault     = 1'b0;

    if (redirect && misaligned) begin
      state_next  = HALT;
      clear_valid = 1'b1;
      set_fault   = 1'b1;
    end else if (redirect) begin
      fetch_pc_next = PCTarget;
      clear_valid   = 1'b1;
      // A redirect never cancels an in-flight response; it must still be drained.
      case (state)
        WAIT, DRAIN: state_next = imem_rvalid ? FETCH : DRAIN;
        default:     state_next = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_gnt) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            load_instr = 1'b1;
            state_next = HOLD;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            state_next = FETCH;
          end
        end
        HOLD: begin
          if (InstrValid && DecodeReady) begin
            clear_valid   = 1'b1;
            fetch_pc_next = fetch_pc + 32'd4;
            state_next    = FETCH;
          end
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      Instr      <= NOP;
      PC         <= RESET_PC;
      PCPlus4    <= RESET_PC + 32'd4;
      InstrValid <= 1'b0;
      Fault      <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_next;
      if (load_instr) begin
        Instr      <= imem_rdata;
        PC         <= fetch_pc;
        PCPlus4    <= fetch_pc + 32'd4;
        InstrValid <= 1'b1;
      end else if (clear_valid) begin
        InstrValid <= 1'b0;
      end
      if (set_fault) begin
        Fault <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit -- directed vector bench for fetch_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        InstrValid;
  logic        DecodeReady;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        Fault;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .InstrValid  (InstrValid),
    .DecodeReady (DecodeReady),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .Fault       (Fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        dr;
    logic        src;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] p4;
    logic        f;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic gnt, input logic rv, input logic [31:0] rdata,
                     input logic dr, input logic src, input logic [31:0] tgt,
                     input logic req, input logic [31:0] addr, input logic iv,
                     input logic [31:0] instr, input logic [31:0] pc,
                     input logic [31:0] p4, input logic f);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.dr = dr; v.src = src; v.tgt = tgt;
    v.req = req; v.addr = addr; v.iv = iv; v.instr = instr; v.pc = pc; v.p4 = p4; v.f = f;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                       input logic dr, input logic src, input logic [31:0] tgt);
    imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rdata;
    DecodeReady = dr; PCSrc = src; PCTarget = tgt;
  endtask

  task automatic chk_regs(input string tag, input logic req, input logic [31:0] addr,
                          input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] p4, input logic f);
    chk({tag, ".req"},   {31'd0, imem_req},   {31'd0, req});
    chk({tag, ".addr"},  imem_addr,           addr);
    chk({tag, ".iv"},    {31'd0, InstrValid}, {31'd0, iv});
    chk({tag, ".instr"}, Instr,               instr);
    chk({tag, ".pc"},    PC,                  pc);
    chk({tag, ".p4"},    PCPlus4,             p4);
    chk({tag, ".fault"}, {31'd0, Fault},      {31'd0, f});
  endtask

  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
  localparam logic [31:0] I0  = 32'h0050_0093;
  localparam logic [31:0] I1  = 32'h0010_0113;
  localparam logic [31:0] I2  = 32'h0000_0513;
  localparam logic [31:0] I3  = 32'h0000_0033;
  localparam logic [31:0] I4  = 32'h0020_0093;
  localparam logic [31:0] TOP = 32'hFFFF_FFFC;

  initial begin
    //   gnt rv rdata dr src tgt      | req addr iv instr pc p4 fault
    add(1, 0, 0,   0, 0, 0,           1, 0,     0, 32'h13, 0, 4, 0);      // c0 first fetch
    add(0, 1, I0,  0, 0, 0,           0, 0,     0, 32'h13, 0, 4, 0);      // c1 WAIT rvalid
    add(0, 0, 0,   1, 0, 0,           0, 0,     1, I0, 0, 4, 0);          // c2 HOLD consume
    add(1, 0, 0,   0, 0, 0,           1, 4,     0, I0, 0, 4, 0);          // c3 fetch @4
    add(0, 1, I1,  0, 0, 0,           0, 4,     0, I0, 0, 4, 0);          // c4
    for (int k = 0; k < 5; k++)
      add(1, 1, BAD, 0, 0, 0,         0, 4,     1, I1, 4, 8, 0);          // c5-c9 stall
    add(0, 0, 0,   1, 0, 0,           0, 4,     1, I1, 4, 8, 0);          // c10 consume
    add(0, 0, 0,   0, 0, 0,           1, 8,     0, I1, 4, 8, 0);          // c11 no grant
    add(1, 0, 0,   0, 0, 0,           1, 8,     0, I1, 4, 8, 0);          // c12 grant
    add(0, 0, 0,   0, 1, 32'h100,     0, 8,     0, I1, 4, 8, 0);          // c13 redirect in WAIT
    add(0, 1, BAD, 0, 0, 0,           0, 32'h100, 0, I1, 4, 8, 0);        // c14 stale drained
    add(1, 0, 0,   0, 0, 0,           1, 32'h100, 0, I1, 4, 8, 0);        // c15
    add(0, 1, I2,  0, 0, 0,           0, 32'h100, 0, I1, 4, 8, 0);        // c16
    add(0, 0, 0,   1, 0, 0,           0, 32'h100, 1, I2, 32'h100, 32'h104, 0); // c17
    add(1, 0, 0,   0, 0, 0,           1, 32'h104, 0, I2, 32'h100, 32'h104, 0); // c18
    add(0, 1, BAD, 0, 1, TOP,         0, 32'h104, 0, I2, 32'h100, 32'h104, 0); // c19 redirect+rvalid
    add(1, 0, 0,   0, 0, 0,           1, TOP,   0, I2, 32'h100, 32'h104, 0);   // c20
    add(0, 1, I3,  0, 0, 0,           0, TOP,   0, I2, 32'h100, 32'h104, 0);   // c21
    add(0, 0, 0,   1, 0, 0,           0, TOP,   1, I3, TOP, 0, 0);        // c22 wrap
    add(0, 0, 0,   0, 0, 0,           1, 0,     0, I3, TOP, 0, 0);        // c23
    add(1, 0, 0,   0, 0, 0,           1, 0,     0, I3, TOP, 0, 0);        // c24
    add(0, 1, I4,  0, 0, 0,           0, 0,     0, I3, TOP, 0, 0);        // c25
    add(0, 0, 0,   1, 1, 32'h40,      0, 0,     1, I4, 0, 4, 0);          // c26 redirect voids handshake
    add(0, 0, 0,   0, 0, 0,           1, 32'h40, 0, I4, 0, 4, 0);         // c27
    add(1, 0, 0,   0, 1, 32'h80,      0, 32'h40, 0, I4, 0, 4, 0);         // c28 redirect in FETCH
    add(0, 0, 0,   0, 0, 0,           1, 32'h80, 0, I4, 0, 4, 0);         // c29
    add(1, 0, 0,   0, 0, 0,           1, 32'h80, 0, I4, 0, 4, 0);         // c30
    add(0, 0, 0,   0, 1, 32'h102,     0, 32'h80, 0, I4, 0, 4, 0);         // c31 misaligned
    add(0, 1, BAD, 1, 0, 0,           0, 32'h80, 0, I4, 0, 4, 1);         // c32 HALT
    for (int k = 0; k < 9; k++)
      add(1, 0, 0, 1, k[0], 32'h200,  0, 32'h80, 0, I4, 0, 4, 1);         // c33-c41 HALT

    drive(1, 1, BAD, 1, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk_regs("rst", 0, 0, 0, 32'h13, 0, 4, 0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].dr, vecs[i].src, vecs[i].tgt);
      #1 chk_regs($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].iv,
                  vecs[i].instr, vecs[i].pc, vecs[i].p4, vecs[i].f);
      @(negedge clk);
    end

    // Asynchronous reset out of HALT, then reset while a request is outstanding.
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1 chk_regs("async_rst", 0, 0, 0, 32'h13, 0, 4, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    #1 chk_regs("first_req", 1, 0, 0, 32'h13, 0, 4, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1 chk_regs("rst_in_wait", 0, 0, 0, 32'h13, 0, 4, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1, BAD, 1, 0, 0);
    #1 chk_regs("stale_rv", 1, 0, 0, 32'h13, 0, 4, 0);
    @(negedge clk);
    drive(1, 0, 0, 1, 0, 0);
    #1 chk_regs("stale_ignored", 1, 0, 0, 32'h13, 0, 4, 0);
    @(negedge clk);
    drive(0, 1, 32'h00A0_0093, 0, 0, 0);
    #1 chk_regs("refetch_wait", 0, 0, 0, 32'h13, 0, 4, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1 chk_regs("refetch_hold", 0, 0, 1, 32'h00A0_0093, 0, 4, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  out  32  word-aligned fetch address.
REQ-006 SHALL have port imem_gnt  in  1  request accepted this cycle.
REQ-007 SHALL have port imem_rvalid  in  1  response data valid.
REQ-008 SHALL have port imem_rdata  in  32  response instruction word.
REQ-009 SHALL have port Instr  out  32  instruction presented to decode; the op field is Instr[6:0].
REQ-010 SHALL have port PC  out  32  address of Instr.
REQ-011 SHALL have port PCPlus4  out  32  PC + 4, modulo 2^32.
REQ-012 SHALL have port InstrValid  out  1  Instr/PC/PCPlus4 valid.
REQ-013 SHALL have port DecodeReady  in  1  decode consumes Instr when InstrValid and DecodeReady are both 1.
REQ-014 SHALL have port PCSrc  in  1  redirect request from branch/jump resolution.
REQ-015 SHALL have port PCTarget  in  32  redirect address.
REQ-016 SHALL have port Fault  out  1  sticky misaligned-target flag.

Function
REQ-017 SHALL implement states FETCH, WAIT, DRAIN, HOLD and HALT, plus a 32-bit fetch_pc register.
REQ-018 SHALL drive imem_req = 1 only in FETCH with PCSrc = 0, and imem_addr = fetch_pc in every state.
REQ-019 FETCH: imem_gnt = 1 SHALL move to WAIT; otherwise remain in FETCH with the request held stable.
REQ-020 WAIT: imem_rvalid = 1 SHALL register imem_rdata into Instr, fetch_pc into PC and fetch_pc + 4 into PCPlus4, set InstrValid and move to HOLD; InstrValid rises the cycle after rvalid.
REQ-021 SHALL ignore imem_rvalid in FETCH, HOLD and HALT, because only one request is ever outstanding.
REQ-022 HOLD: on handshake (InstrValid and DecodeReady), SHALL clear InstrValid, set fetch_pc = fetch_pc + 4 (wraps from 32'hFFFF_FFFC to 0) and move to FETCH.
REQ-023 HOLD with DecodeReady = 0: Instr, PC, PCPlus4 and InstrValid SHALL hold unchanged.
REQ-024 PCSrc = 1 with PCTarget[1:0] = 0 SHALL set fetch_pc = PCTarget and take priority over every other event in the same cycle.
REQ-025 Redirect in FETCH or HOLD SHALL go to FETCH and clear InstrValid; any handshake in that cycle is void.
REQ-026 Redirect in WAIT without rvalid SHALL go to DRAIN; redirect in WAIT with rvalid SHALL discard the data and go to FETCH.
REQ-027 DRAIN: SHALL wait for imem_rvalid, discard the data, then go to FETCH; InstrValid stays 0; a further redirect in DRAIN only updates fetch_pc.
REQ-028 PCSrc = 1 with PCTarget[1:0] != 0 SHALL set Fault, clear InstrValid and go to HALT; an outstanding response is still discarded.
REQ-029 HALT: SHALL keep imem_req = 0, InstrValid = 0 and Fault = 1 until reset, and SHALL ignore all further PCSrc.
REQ-030 Throughput with single-cycle gnt, next-cycle rvalid and DecodeReady = 1 SHALL be one instruction per 3 cycles.

Reset
REQ-031 While reset is 1: state = FETCH, fetch_pc = RESET_PC, Instr = 32'h0000_0013 (nop), PC = RESET_PC, PCPlus4 = RESET_PC + 4, InstrValid = 0, Fault = 0, and imem_req = 0.
REQ-032 Reset asserted mid-request SHALL abandon the request; the first post-reset response is not expected and SHALL be ignored outside WAIT.
REQ-033 The first imem_req SHALL assert in the first cycle after reset deasserts, with imem_addr = RESET_PC.

Verification
REQ-034 Reset release with gnt = 1, rvalid the next cycle, rdata = 32'h00500093, DecodeReady = 1 -> InstrValid high one cycle with PC = 0 and Instr = 32'h00500093; the next imem_addr is 4.
REQ-035 DecodeReady held 0 for 5 cycles in HOLD -> outputs stable and no imem_req; DecodeReady = 1 -> the next fetch is at PC + 4.
REQ-036 PCSrc = 1 with PCTarget = 32'h100 in WAIT, then stale rvalid with rdata = 32'hDEADBEEF -> data never appears on Instr, and the next imem_addr is 32'h100.
REQ-037 PCSrc = 1 with PCTarget = 32'h102 -> Fault = 1 and HALT; imem_req stays 0 for 10 cycles despite further PCSrc pulses.
REQ-038 fetch_pc = 32'hFFFF_FFFC consumed -> PCPlus4 = 0 and the next imem_addr is 0.
REQ-039 Reset asserted in WAIT, then rvalid arriving after release while in FETCH -> ignored; the first fetch is at RESET_PC.
